// File: rtl/uart.sv
// uart: memory-mapped 8N1 UART on the CPU data/IO bus.
//
// Register window (offset from BASE inside the I/O page):
//   +0 DATA    write pushes into the TX FIFO, read returns rx_data and clears rx_valid
//   +1 STATUS  {0, tx_ovf, rx_fe, rx_ovr, rx_valid, tx_busy, tx_full, tx_empty}
//              a read clears bits 4..6
//   +2 DIV_LO  low byte of the baud divider
//   +3 DIV_HI  high byte of the baud divider
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   address  CPU bus address; only address[7:0] is decoded
//   din      CPU write data
//   w_en     write strobe
//   r_en     read strobe
//   dout     registered read data, one-cycle latency, holds between reads
//   tx       serial output, idles high
//   rx       serial input, asynchronous to clk
module uart #(
  parameter logic [7:0]  BASE        = 8'h10,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd104
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] address,
  input  logic [7:0]  din,
  input  logic        w_en,
  input  logic        r_en,
  output logic [7:0]  dout,
  output logic        tx,
  input  logic        rx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Address decode. The page (address[15:8]) is decoded upstream.
  logic [7:0] offset;
  logic       in_win;
  logic [1:0] sel;
  logic       unused_addr;

  assign offset      = address[7:0] - BASE;
  assign in_win      = (offset[7:2] == 6'd0);
  assign sel         = offset[1:0];
  assign unused_addr = ^address[15:8];

  logic wr_data, rd_data, rd_status, wr_div_lo, wr_div_hi;
  assign wr_data   = w_en && in_win && (sel == 2'd0);
  assign wr_div_lo = w_en && in_win && (sel == 2'd2);
  assign wr_div_hi = w_en && in_win && (sel == 2'd3);
  assign rd_data   = r_en && in_win && (sel == 2'd0);
  assign rd_status = r_en && in_win && (sel == 2'd1);

  logic [15:0] div;
  logic [15:0] div_eff;
  assign div_eff = (div < 16'd2) ? 16'd2 : div;

  // ---------------- TX FIFO ----------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          fifo_empty, fifo_full;
  logic          push, tx_pop;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_COUNT);
  // A push into a full FIFO still fits when the serializer pops the same cycle.
  assign push       = wr_data && (!fifo_full || tx_pop);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (tx_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, tx_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- TX serializer ----------------
  logic [1:0]  tx_state;
  logic [15:0] tx_cnt, tx_div;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_bit_end;

  assign tx_bit_end = (tx_cnt == tx_div - 16'd1);
  // Pop from IDLE, or straight out of STOP so frames run with no idle gap.
  assign tx_pop = !fifo_empty &&
                  ((tx_state == S_IDLE) || ((tx_state == S_STOP) && tx_bit_end));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= S_IDLE;
      tx       <= 1'b1;
      tx_cnt   <= '0;
      tx_div   <= 16'd2;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (tx_pop) begin
            tx_state <= S_START;
            tx       <= 1'b0;
            tx_cnt   <= '0;
            tx_shift <= fifo_mem[rd_ptr];
            tx_div   <= div_eff;
          end
        end
        S_START: begin
          if (tx_bit_end) begin
            tx_state <= S_DATA;
            tx       <= tx_shift[0];
            tx_cnt   <= '0;
            tx_bit   <= '0;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state <= S_STOP;
              tx       <= 1'b1;
            end else begin
              tx_bit <= tx_bit + 3'd1;
              tx     <= tx_shift[tx_bit + 3'd1];
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        default: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_pop) begin
              tx_state <= S_START;
              tx       <= 1'b0;
              tx_shift <= fifo_mem[rd_ptr];
              tx_div   <= div_eff;
            end else begin
              tx_state <= S_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // ---------------- RX deserializer ----------------
  // rx_s1/rx_s2 synchronize; rx_s3 is the previous synchronized value for edge detect.
  logic rx_s1, rx_s2, rx_s3, rx_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_fall = rx_s3 && !rx_s2;

  logic [1:0]  rx_state;
  logic [15:0] rx_cnt, rx_div;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_bit_end, rx_half_end, rx_load, rx_ferr;

  assign rx_bit_end  = (rx_cnt == rx_div - 16'd1);
  assign rx_half_end = (rx_cnt == (rx_div >> 1) - 16'd1);
  assign rx_load     = (rx_state == S_STOP) && rx_bit_end && rx_s2;
  assign rx_ferr     = (rx_state == S_STOP) && rx_bit_end && !rx_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_div   <= 16'd2;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          if (rx_fall) begin
            rx_state <= S_START;
            rx_cnt   <= '0;
            rx_div   <= div_eff;
          end
        end
        S_START: begin
          // Mid-bit resample; a high line here means the edge was a glitch.
          if (rx_half_end) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (rx_bit_end) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        default: begin
          if (rx_bit_end) begin
            rx_cnt   <= '0;
            rx_state <= S_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // ---------------- Registers, flags and read port ----------------
  logic [7:0] rx_data;
  logic       rx_valid, rx_ovr, rx_fe, tx_ovf;
  logic       tx_busy;
  logic [7:0] status;
  logic [7:0] read_mux;

  assign tx_busy = (tx_state != S_IDLE) || !fifo_empty;
  assign status  = {1'b0, tx_ovf, rx_fe, rx_ovr, rx_valid, tx_busy, fifo_full, fifo_empty};

  always_comb begin
    read_mux = 8'h00;
    case (sel)
      2'd0:    read_mux = rx_data;
      2'd1:    read_mux = status;
      2'd2:    read_mux = div[7:0];
      default: read_mux = div[15:8];
    endcase
  end

  // Each flag lists its set condition first so a same-cycle set beats the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_ovr   <= 1'b0;
      rx_fe    <= 1'b0;
      tx_ovf   <= 1'b0;
      div      <= DEFAULT_DIV;
      dout     <= '0;
    end else begin
      if (rx_load) rx_data <= rx_shift;

      if (rx_load)      rx_valid <= 1'b1;
      else if (rd_data) rx_valid <= 1'b0;

      if (rx_load && rx_valid) rx_ovr <= 1'b1;
      else if (rd_status)      rx_ovr <= 1'b0;

      if (rx_ferr)        rx_fe <= 1'b1;
      else if (rd_status) rx_fe <= 1'b0;

      if (wr_data && fifo_full && !tx_pop) tx_ovf <= 1'b1;
      else if (rd_status)                  tx_ovf <= 1'b0;

      if (wr_div_lo) div[7:0]  <= din;
      if (wr_div_hi) div[15:8] <= din;

      if (r_en && in_win) dout <= read_mux;
    end
  end

endmodule

// File: tb/tb_uart.sv
// tb_uart: self-checking bench for uart.
// A frame-level model (list of scheduled TX frames, event-level RX flags)
// predicts tx and dout; a compare process checks them every cycle, and
// directed literal checks pin the model to hand-computed values.
module tb_uart;

  localparam logic [7:0] BASE       = 8'h10;
  localparam int         FIFO_DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] address;
  logic [7:0]  din;
  logic        w_en;
  logic        r_en;
  logic [7:0]  dout;
  logic        tx;
  logic        rx;

  uart #(
    .BASE(BASE),
    .FIFO_DEPTH(FIFO_DEPTH),
    .DEFAULT_DIV(16'd104)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .address(address),
    .din(din),
    .w_en(w_en),
    .r_en(r_en),
    .dout(dout),
    .tx(tx),
    .rx(rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Model state
  int         f_push[$];
  int         f_start[$];
  int         f_div[$];
  logic [7:0] f_byte[$];
  logic [15:0] m_div;
  logic [7:0]  m_rx_data;
  logic        m_rx_valid, m_rx_ovr, m_rx_fe, m_tx_ovf;
  logic [7:0]  exp_dout;

  function automatic logic model_tx(int t);
    for (int i = 0; i < f_start.size(); i++) begin
      int s = f_start[i];
      int d = f_div[i];
      if (t >= s && t < s + 10*d) begin
        int k = (t - s) / d;
        logic [7:0] b = f_byte[i];
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
      end
    end
    return 1'b1;
  endfunction

  // Bytes pushed by edge e and not yet popped after edge e.
  function automatic int fifo_count(int e);
    int n = 0;
    for (int i = 0; i < f_start.size(); i++)
      if (f_push[i] <= e && f_start[i] > e) n++;
    return n;
  endfunction

  function automatic bit tx_active(int e);
    for (int i = 0; i < f_start.size(); i++)
      if (e >= f_start[i] && e < f_start[i] + 10*f_div[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int line_free();
    int n = f_start.size();
    if (n == 0) return 0;
    return f_start[n-1] + 10*f_div[n-1];
  endfunction

  function automatic logic [7:0] model_status(int e);
    int  n    = fifo_count(e);
    bit  busy = tx_active(e) || (n != 0);
    return {1'b0, m_tx_ovf, m_rx_fe, m_rx_ovr, m_rx_valid, busy,
            (n == FIFO_DEPTH), (n == 0)};
  endfunction

  task automatic clearModel();
    f_push.delete();
    f_start.delete();
    f_div.delete();
    f_byte.delete();
    m_div      = 16'd104;
    m_rx_data  = 8'h00;
    m_rx_valid = 1'b0;
    m_rx_ovr   = 1'b0;
    m_rx_fe    = 1'b0;
    m_tx_ovf   = 1'b0;
    exp_dout   = 8'h00;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
    end
  endtask

  // Every cycle outside reset, tx and dout must match the model.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("tx_line", {7'b0, tx}, {7'b0, model_tx(cyc)});
      checkOutput("dout", dout, exp_dout);
    end
  end

  // One bus operation, sampled by the next rising edge.
  task automatic applyStimulus(input bit w, input bit r, input logic [1:0] off, input logic [7:0] data);
    int         e;
    int         d;
    int         s;
    logic [7:0] rv;
    @(negedge clk);
    address = {8'h10, BASE + {6'b0, off}};
    din     = data;
    w_en    = w;
    r_en    = r;
    e  = cyc + 1;
    rv = exp_dout;
    if (r) begin
      case (off)
        2'd0: begin rv = m_rx_data; m_rx_valid = 1'b0; end
        2'd1: begin
          rv = model_status(e - 1);
          m_tx_ovf = 1'b0;
          m_rx_ovr = 1'b0;
          m_rx_fe  = 1'b0;
        end
        2'd2: rv = m_div[7:0];
        default: rv = m_div[15:8];
      endcase
    end
    if (w) begin
      case (off)
        2'd0: begin
          if (fifo_count(e) < FIFO_DEPTH) begin
            d = (m_div < 16'd2) ? 2 : int'(m_div);
            s = line_free();
            if (s < e + 1) s = e + 1;
            f_push.push_back(e);
            f_start.push_back(s);
            f_div.push_back(d);
            f_byte.push_back(data);
          end else begin
            m_tx_ovf = 1'b1;
          end
        end
        2'd2: m_div[7:0]  = data;
        2'd3: m_div[15:8] = data;
        default: ;
      endcase
    end
    @(posedge clk);
    if (r) exp_dout = rv;
  endtask

  task automatic busIdle();
    @(negedge clk);
    w_en = 1'b0;
    r_en = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    clearModel();
    #1;
    checkOutput("reset_tx", {7'b0, tx}, 8'h01);
    checkOutput("reset_dout", dout, 8'h00);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic sendRx(input logic [7:0] b, input logic stop_bit, input int d);
    @(negedge clk);
    rx = 1'b0;
    repeat (d) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (d) @(negedge clk);
    end
    rx = stop_bit;
    repeat (d) @(negedge clk);
    rx = 1'b1;
    repeat (d) @(negedge clk);
    if (stop_bit) begin
      if (m_rx_valid) m_rx_ovr = 1'b1;
      m_rx_valid = 1'b1;
      m_rx_data  = b;
    end else begin
      m_rx_fe = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  logic a5_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  int   n0;

  initial begin
    rst_n   = 1'b0;
    address = 16'h0000;
    din     = 8'h00;
    w_en    = 1'b0;
    r_en    = 1'b0;
    rx      = 1'b1;
    clearModel();
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Start a frame at the default divider and reset in the middle of it.
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h5A);
    busIdle();
    repeat (50) @(negedge clk);
    checkOutput("midframe_tx_low", {7'b0, tx}, 8'h00);
    #2;
    doReset();

    applyStimulus(1'b0, 1'b1, 2'd1, 8'h00);
    busIdle();
    checkOutput("reset_status", dout, 8'h01);
    applyStimulus(1'b0, 1'b1, 2'd2, 8'h00);
    busIdle();
    checkOutput("reset_div_lo", dout, 8'h68);
    applyStimulus(1'b0, 1'b1, 2'd3, 8'h00);
    busIdle();
    checkOutput("reset_div_hi", dout, 8'h00);

    // Single byte at DIV=16.
    applyStimulus(1'b1, 1'b0, 2'd2, 8'd16);
    applyStimulus(1'b1, 1'b0, 2'd3, 8'd0);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'hA5);
    busIdle();
    @(negedge clk);
    checkOutput("a5_start", {7'b0, tx}, 8'h00);
    for (int k = 0; k < 8; k++) begin
      repeat (16) @(negedge clk);
      checkOutput("a5_bit", {7'b0, tx}, {7'b0, a5_bits[k]});
    end
    repeat (16) @(negedge clk);
    checkOutput("a5_stop", {7'b0, tx}, 8'h01);
    repeat (20) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 2'd1, 8'h00);
    busIdle();
    checkOutput("a5_done_status", dout, 8'h01);

    // FIFO fill and overflow at DIV=4.
    applyStimulus(1'b1, 1'b0, 2'd2, 8'd4);
    n0 = f_start.size();
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h11);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h22);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h33);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h44);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h55);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h66);
    applyStimulus(1'b0, 1'b1, 2'd1, 8'h00);
    checkOutput("fifo_accepted", 8'(f_start.size() - n0), 8'd5);
    applyStimulus(1'b0, 1'b1, 2'd1, 8'h00);
    busIdle();
    checkOutput("full_status_cleared", dout, 8'h06);
    repeat (5*40 + 10) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 2'd1, 8'h00);
    busIdle();
    checkOutput("drained_status", dout, 8'h01);

    // Read and write of the same register in one cycle, then out-of-window access.
    applyStimulus(1'b1, 1'b1, 2'd2, 8'd16);
    busIdle();
    checkOutput("rw_same_cycle_old", dout, 8'h04);
    @(negedge clk);
    address = {8'h10, BASE + 8'h04};
    din     = 8'hEE;
    w_en    = 1'b1;
    r_en    = 1'b1;
    busIdle();
    checkOutput("out_of_window_hold", dout, 8'h04);
    applyStimulus(1'b0, 1'b1, 2'd2, 8'h00);
    busIdle();
    checkOutput("div_lo_new", dout, 8'h10);

    // Receive one byte at DIV=16.
    sendRx(8'h3C, 1'b1, 16);
    applyStimulus(1'b0, 1'b1, 2'd1, 8'h00);
    busIdle();
    checkOutput("rx_status_valid", dout, 8'h09);
    applyStimulus(1'b0, 1'b1, 2'd0, 8'h00);
    busIdle();
    checkOutput("rx_data_3c", dout, 8'h3C);
    applyStimulus(1'b0, 1'b1, 2'd1, 8'h00);
    busIdle();
    checkOutput("rx_status_after_read", dout, 8'h01);

    // Overrun, then a framing error.
    sendRx(8'h55, 1'b1, 16);
    sendRx(8'hA1, 1'b1, 16);
    applyStimulus(1'b0, 1'b1, 2'd1, 8'h00);
    busIdle();
    checkOutput("rx_overrun_status", dout, 8'h19);
    applyStimulus(1'b0, 1'b1, 2'd0, 8'h00);
    busIdle();
    checkOutput("rx_overrun_data", dout, 8'hA1);
    sendRx(8'hF0, 1'b0, 16);
    applyStimulus(1'b0, 1'b1, 2'd1, 8'h00);
    busIdle();
    checkOutput("rx_fe_status", dout, 8'h21);
    applyStimulus(1'b0, 1'b1, 2'd1, 8'h00);
    busIdle();
    checkOutput("rx_fe_cleared", dout, 8'h01);

    // Short low glitch must be rejected; a following frame still receives.
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 2'd1, 8'h00);
    busIdle();
    checkOutput("glitch_status", dout, 8'h01);
    sendRx(8'hC3, 1'b1, 16);
    applyStimulus(1'b0, 1'b1, 2'd0, 8'h00);
    busIdle();
    checkOutput("post_glitch_data", dout, 8'hC3);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
